// File: rtl/flop_prim_bank.sv
`default_nettype none
// ============================================================================
// Module      : flop_prim_bank
// Description : Three lanes of behavioural flip-flops on one clock, modelling
//               FDCE (async clear), FDPE (async preset) and FDSE (sync set)
//               register primitives. Every bit is an independent flop.
//               A block-level async active-low reset restores INIT values.
// Revision    : 1.0 - initial release
// ============================================================================
module flop_prim_bank #(
  parameter int          WIDTH           = 1,
  parameter logic [WIDTH-1:0] INIT_C     = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] INIT_P     = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] INIT_S     = {WIDTH{1'b1}},
  parameter logic        IS_CLR_INVERTED = 1'b0,
  parameter logic        IS_PRE_INVERTED = 1'b0,
  parameter logic        IS_S_INVERTED   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  // Lane C: clock enable + asynchronous clear
  input  logic [WIDTH-1:0] ce_c_i,
  input  logic [WIDTH-1:0] d_c_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] q_c_o,
  // Lane P: clock enable + asynchronous preset
  input  logic [WIDTH-1:0] ce_p_i,
  input  logic [WIDTH-1:0] d_p_i,
  input  logic [WIDTH-1:0] pre_i,
  output logic [WIDTH-1:0] q_p_o,
  // Lane S: clock enable + synchronous set
  input  logic [WIDTH-1:0] ce_s_i,
  input  logic [WIDTH-1:0] d_s_i,
  input  logic [WIDTH-1:0] s_i,
  output logic [WIDTH-1:0] q_s_o
);

  // Effective (active-high) control levels after optional inversion
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_pre;
  logic [WIDTH-1:0] w_set;

  assign w_clr = clr_i ^ {WIDTH{IS_CLR_INVERTED}};
  assign w_pre = pre_i ^ {WIDTH{IS_PRE_INVERTED}};
  assign w_set = s_i   ^ {WIDTH{IS_S_INVERTED}};

  logic [WIDTH-1:0] r_q_c;
  logic [WIDTH-1:0] r_q_p;
  logic [WIDTH-1:0] r_q_s;

  // Each bit owns its own async control, so each bit is a separate process.
  // An X/Z clock enable evaluates false in the if and the flop holds.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit

    // Lane C bit: reset to INIT, async clear to 0, else enabled capture
    always_ff @(posedge clk_i or negedge rst_n_i or posedge w_clr[i]) begin
      if (!rst_n_i) begin
        r_q_c[i] <= INIT_C[i];
      end else if (w_clr[i]) begin
        r_q_c[i] <= 1'b0;
      end else if (ce_c_i[i]) begin
        r_q_c[i] <= d_c_i[i];
      end
    end

    // Lane P bit: reset to INIT, async preset to 1, else enabled capture
    always_ff @(posedge clk_i or negedge rst_n_i or posedge w_pre[i]) begin
      if (!rst_n_i) begin
        r_q_p[i] <= INIT_P[i];
      end else if (w_pre[i]) begin
        r_q_p[i] <= 1'b1;
      end else if (ce_p_i[i]) begin
        r_q_p[i] <= d_p_i[i];
      end
    end

    // Lane S bit: reset to INIT, sync set beats enable, else enabled capture
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_q_s[i] <= INIT_S[i];
      end else if (w_set[i]) begin
        r_q_s[i] <= 1'b1;
      end else if (ce_s_i[i]) begin
        r_q_s[i] <= d_s_i[i];
      end
    end

  end : g_bit

  assign q_c_o = r_q_c;
  assign q_p_o = r_q_p;
  assign q_s_o = r_q_s;

endmodule : flop_prim_bank
`default_nettype wire

// File: tb/tb_flop_prim_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_flop_prim_bank
// Description : Directed scoreboard bench for flop_prim_bank. Instance A uses
//               default polarities, instance B has all controls inverted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flop_prim_bank;

  localparam int W = 4;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b1;

  // Instance A stimulus / response
  logic [W-1:0] ce_c_a = '0, d_c_a = '0, clr_a = '0, q_c_a;
  logic [W-1:0] ce_p_a = '0, d_p_a = '0, pre_a = '0, q_p_a;
  logic [W-1:0] ce_s_a = '0, d_s_a = '0, s_a   = '0, q_s_a;
  // Instance B stimulus / response (inactive control level is 1)
  logic [W-1:0] ce_c_b = '0, d_c_b = '0, clr_b = '1, q_c_b;
  logic [W-1:0] ce_p_b = '0, d_p_b = '0, pre_b = '1, q_p_b;
  logic [W-1:0] ce_s_b = '0, d_s_b = '0, s_b   = '1, q_s_b;

  always #5 clk_i = ~clk_i;

  flop_prim_bank #(.WIDTH(W)) u_dut_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ce_c_i(ce_c_a), .d_c_i(d_c_a), .clr_i(clr_a), .q_c_o(q_c_a),
    .ce_p_i(ce_p_a), .d_p_i(d_p_a), .pre_i(pre_a), .q_p_o(q_p_a),
    .ce_s_i(ce_s_a), .d_s_i(d_s_a), .s_i(s_a),     .q_s_o(q_s_a)
  );

  flop_prim_bank #(
    .WIDTH(W), .IS_CLR_INVERTED(1'b1), .IS_PRE_INVERTED(1'b1), .IS_S_INVERTED(1'b1)
  ) u_dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ce_c_i(ce_c_b), .d_c_i(d_c_b), .clr_i(clr_b), .q_c_o(q_c_b),
    .ce_p_i(ce_p_b), .d_p_i(d_p_b), .pre_i(pre_b), .q_p_o(q_p_b),
    .ce_s_i(ce_s_b), .d_s_i(d_s_b), .s_i(s_b),     .q_s_o(q_s_b)
  );

  typedef struct {
    string        nm;
    bit           dut_b;
    logic [W-1:0] c;
    logic [W-1:0] p;
    logic [W-1:0] s;
  } exp_t;

  exp_t sb[$];
  event ev_chk;
  int   n_vec = 0;
  int   n_err = 0;

  // Monitor: drains the scoreboard whenever stimulus announces a sample point
  initial begin
    forever begin
      @(ev_chk);
      while (sb.size() != 0) begin
        exp_t e;
        logic [W-1:0] ac, ap, as_;
        e   = sb.pop_front();
        ac  = e.dut_b ? q_c_b : q_c_a;
        ap  = e.dut_b ? q_p_b : q_p_a;
        as_ = e.dut_b ? q_s_b : q_s_a;
        n_vec++;
        if (ac !== e.c) begin
          n_err++;
          $display("FAIL %s q_c: got %h expected %h", e.nm, ac, e.c);
        end
        if (ap !== e.p) begin
          n_err++;
          $display("FAIL %s q_p: got %h expected %h", e.nm, ap, e.p);
        end
        if (as_ !== e.s) begin
          n_err++;
          $display("FAIL %s q_s: got %h expected %h", e.nm, as_, e.s);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string nm, input bit dut_b,
                     input logic [W-1:0] c, input logic [W-1:0] p,
                     input logic [W-1:0] s);
    #1;
    sb.push_back('{nm, dut_b, c, p, s});
    -> ev_chk;
  endtask

  initial begin
    // Reset asserts mid-cycle and takes effect without a clock edge
    #2 rst_n_i = 1'b0;
    chk("reset_a", 1'b0, 4'h0, 4'hF, 4'hF);
    chk("reset_b", 1'b1, 4'h0, 4'hF, 4'hF);

    // Reset overrides sync set and enables across edges
    s_a = 4'hF; ce_c_a = 4'hF; d_c_a = 4'hF; ce_p_a = 4'hF; d_p_a = 4'h0;
    tick(); tick();
    chk("rst_prio", 1'b0, 4'h0, 4'hF, 4'hF);
    ce_c_a = '0; d_c_a = '0; ce_p_a = '0;
    rst_n_i = 1'b1;
    chk("rst_release", 1'b0, 4'h0, 4'hF, 4'hF);
    tick();
    chk("set_after_rel", 1'b0, 4'h0, 4'hF, 4'hF);
    s_a = 4'h0;

    // Lane C enable/hold
    ce_c_a = 4'b0101; d_c_a = 4'hA;
    tick();
    chk("ce_partial", 1'b0, 4'h0, 4'hF, 4'hF);
    ce_c_a = 4'hF; d_c_a = 4'h6;
    tick();
    chk("ce_full", 1'b0, 4'h6, 4'hF, 4'hF);
    ce_c_a = 4'b0101; d_c_a = 4'hF;
    tick();
    chk("ce_hold_mix", 1'b0, 4'h7, 4'hF, 4'hF);

    // Lane C async clear
    ce_c_a = 4'hF; d_c_a = 4'hF;
    tick();
    chk("c_load_f", 1'b0, 4'hF, 4'hF, 4'hF);
    clr_a = 4'b0010;
    chk("clr_async", 1'b0, 4'hD, 4'hF, 4'hF);
    tick();
    chk("clr_beats_ce", 1'b0, 4'hD, 4'hF, 4'hF);
    clr_a = 4'h0;
    chk("clr_release", 1'b0, 4'hD, 4'hF, 4'hF);
    tick();
    chk("clr_reload", 1'b0, 4'hF, 4'hF, 4'hF);
    ce_c_a = '0;

    // Lane P async preset
    ce_p_a = 4'hF; d_p_a = 4'h0;
    tick();
    chk("p_load_0", 1'b0, 4'hF, 4'h0, 4'hF);
    pre_a = 4'b1000;
    chk("pre_async", 1'b0, 4'hF, 4'h8, 4'hF);
    tick();
    chk("pre_beats_ce", 1'b0, 4'hF, 4'h8, 4'hF);
    pre_a = 4'h0;
    chk("pre_release", 1'b0, 4'hF, 4'h8, 4'hF);
    tick();
    chk("pre_reload", 1'b0, 4'hF, 4'h0, 4'hF);
    ce_p_a = '0;

    // Lane S synchronous set
    ce_s_a = 4'hF; d_s_a = 4'h0;
    tick();
    chk("s_load_0", 1'b0, 4'hF, 4'h0, 4'h0);
    ce_s_a = 4'h0; s_a = 4'h3;
    chk("set_no_edge", 1'b0, 4'hF, 4'h0, 4'h0);
    tick();
    chk("set_edge", 1'b0, 4'hF, 4'h0, 4'h3);
    s_a = 4'h0;
    tick();
    chk("s_hold", 1'b0, 4'hF, 4'h0, 4'h3);
    s_a = 4'h4; ce_s_a = 4'hF; d_s_a = 4'h0;
    tick();
    chk("set_beats_ce", 1'b0, 4'hF, 4'h0, 4'h4);
    s_a = 4'h0; ce_s_a = 4'h0;

    // Instance B: every control active-low
    ce_s_b = 4'hF; d_s_b = 4'h0; ce_c_b = 4'hF; d_c_b = 4'hF;
    ce_p_b = 4'hF; d_p_b = 4'h0;
    tick();
    chk("inv_idle", 1'b1, 4'hF, 4'h0, 4'h0);
    ce_c_b = '0; ce_p_b = '0;
    s_b = 4'b1110;
    tick();
    chk("inv_set", 1'b1, 4'hF, 4'h0, 4'h1);
    clr_b = 4'b1011;
    chk("inv_clr", 1'b1, 4'hB, 4'h0, 4'h1);
    pre_b = 4'b0111;
    chk("inv_pre", 1'b1, 4'hB, 4'h8, 4'h1);
    clr_b = '1; pre_b = '1; s_b = '1;

    // Mid-run async reset returns both instances to INIT at once
    tick();
    rst_n_i = 1'b0;
    chk("reset_run_a", 1'b0, 4'h0, 4'hF, 4'hF);
    chk("reset_run_b", 1'b1, 4'h0, 4'hF, 4'hF);
    rst_n_i = 1'b1;

    #5;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_flop_prim_bank
`default_nettype wire
